// File: rtl/stack_pkg.sv
// Shared definitions for the Forth stack engine: command opcodes and FSM states.
package stack_pkg;

    localparam int unsigned OP_WIDTH = 2;

    // Command opcodes presented on cmd_op
    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    // Controller states: IDLE accepts commands, REFILL waits for the RAM read of the new NOS
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/stack_ram_ctrl.sv
// Forth data/return stack engine: TOS/NOS in registers, deeper cells spilled to an
// external single-port synchronous RAM (one-cycle read latency).
// Optional build macro: STACK_CTRL_PEAK_EN adds a peak-depth output.
module stack_ram_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      tos,
    output logic [WIDTH-1:0]      nos,
    output logic [CNT_WIDTH-1:0]  depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
`ifdef STACK_CTRL_PEAK_EN
    output logic [CNT_WIDTH-1:0]  peak,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_write_en,
    input  logic [WIDTH-1:0]      mem_rdata
);

    // sp counts 0..DEPTH inclusive, so it needs one bit more than the RAM address
    localparam int unsigned SP_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH + 2);
    localparam logic [CNT_WIDTH-1:0] TWO_CNT  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] THREE_CNT = CNT_WIDTH'(3);

    state_e                 state;
    state_e                 state_next;
    op_e                    op;
    logic [SP_WIDTH-1:0]    sp;
    logic [SP_WIDTH-1:0]    sp_next;
    logic [WIDTH-1:0]       tos_next;
    logic [WIDTH-1:0]       nos_next;
    logic [CNT_WIDTH-1:0]   depth_next;
    logic                   overflow_next;
    logic                   underflow_next;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign empty     = (depth == '0);
    assign full      = (depth == FULL_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath next values and RAM strobes
    always_comb begin
        state_next     = state;
        sp_next        = sp;
        tos_next       = tos;
        nos_next       = nos;
        depth_next     = depth;
        overflow_next  = overflow & ~clr_err;
        underflow_next = underflow & ~clr_err;
        mem_addr       = ADDR_WIDTH'(sp);
        mem_wdata      = nos;
        mem_write_en   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_PUSH: begin
                            if (full) begin
                                overflow_next = 1'b1;
                            end else begin
                                tos_next   = cmd_data;
                                nos_next   = tos;
                                depth_next = depth + CNT_WIDTH'(1);
                                // Old NOS drops into RAM once both registers are occupied
                                if (depth >= TWO_CNT) begin
                                    mem_write_en = 1'b1;
                                    sp_next      = sp + SP_WIDTH'(1);
                                end
                            end
                        end
                        OP_POP: begin
                            if (empty) begin
                                underflow_next = 1'b1;
                            end else begin
                                tos_next   = nos;
                                depth_next = depth - CNT_WIDTH'(1);
                                // A spilled cell becomes the new NOS; fetch it and stall one cycle
                                if (depth >= THREE_CNT) begin
                                    mem_addr   = ADDR_WIDTH'(sp - SP_WIDTH'(1));
                                    sp_next    = sp - SP_WIDTH'(1);
                                    state_next = ST_REFILL;
                                end else begin
                                    nos_next = '0;
                                end
                            end
                        end
                        OP_REPL: begin
                            if (empty) begin
                                underflow_next = 1'b1;
                            end else begin
                                tos_next = cmd_data;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_REFILL: begin
                nos_next   = mem_rdata;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stack registers, spill pointer and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos       <= '0;
            nos       <= '0;
            depth     <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_next;
            nos       <= nos_next;
            depth     <= depth_next;
            sp        <= sp_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

`ifdef STACK_CTRL_PEAK_EN
    // High-water mark of depth, restarted from the current depth by clr_err
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (clr_err) begin
            peak <= depth;
        end else if (depth > peak) begin
            peak <= depth;
        end
    end
`endif

endmodule

// File: tb/tb_stack_ram_ctrl.sv
// Bench for stack_ram_ctrl with DEPTH=4: directed scenarios plus random commands,
// scored against a queue-based stack model and a one-cycle-latency RAM model.
module tb_stack_ram_ctrl;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned ADDR_WIDTH = 2;
    localparam int unsigned CNT_WIDTH  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [WIDTH-1:0]      cmd_data;
    logic                  clr_err;
    logic [WIDTH-1:0]      tos;
    logic [WIDTH-1:0]      nos;
    logic [CNT_WIDTH-1:0]  depth;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  mem_write_en;
    logic [WIDTH-1:0]      mem_rdata;

    logic [WIDTH-1:0]      ram [DEPTH];

    typedef struct {
        logic [WIDTH-1:0] tos;
        logic [WIDTH-1:0] nos;
        int               depth;
        bit               ovf;
        bit               unf;
        int               stall;
    } exp_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } wr_t;

    exp_t             exp_q[$];
    wr_t              wr_q[$];
    logic [WIDTH-1:0] stk[$];
    bit               m_ovf;
    bit               m_unf;
    int               n_cmp = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    stack_ram_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .clr_err(clr_err),
        .tos(tos),
        .nos(nos),
        .depth(depth),
        .empty(empty),
        .full(full),
        .overflow(overflow),
        .underflow(underflow),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_write_en(mem_write_en),
        .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM, read data one cycle after the address
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Present one command, update the reference stack, queue the expected outcome
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data, input bit clr, input bit rst_in_refill);
        int   n;
        int   sz;
        exp_t e;
        wr_t  w;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 8) begin
            cmd_valid = 1'b0;
            clr_err   = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        clr_err   = clr;

        sz      = stk.size();
        e.stall = 0;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (op)
            2'd1: begin
                if (sz == DEPTH + 2) begin
                    m_ovf = 1'b1;
                end else begin
                    if (sz >= 2) begin
                        w.addr = ADDR_WIDTH'(sz - 2);
                        w.data = stk[sz-2];
                        wr_q.push_back(w);
                    end
                    stk.push_back(data);
                end
            end
            2'd2: begin
                if (sz == 0) begin
                    m_unf = 1'b1;
                end else begin
                    if (sz >= 3) e.stall = 1;
                    void'(stk.pop_back());
                end
            end
            2'd3: begin
                if (sz == 0) m_unf = 1'b1;
                else stk[sz-1] = data;
            end
            default: begin
            end
        endcase
        if (rst_in_refill) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        e.tos   = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        e.nos   = (stk.size() > 1) ? stk[stk.size()-2] : '0;
        e.depth = stk.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    // Stop issuing and let the monitor drain every outstanding expectation
    task automatic idle();
        int n;
        @(negedge clk);
        cmd_valid = 1'b0;
        clr_err   = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: score RAM writes and the settled state after each accepted command
    initial begin
        exp_t e;
        wr_t  w;
        int   stall;
        @(posedge rst_n);
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (mem_write_en) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(w.addr));
                        check("wr_data", 32'(mem_wdata), 32'(w.data));
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_accept", 32'(cmd_op), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        stall = 0;
                        @(negedge clk);
                        while (!cmd_ready && stall < 4) begin
                            stall++;
                            @(negedge clk);
                        end
                        check("stall", 32'(stall), 32'(e.stall));
                        check("tos", 32'(tos), 32'(e.tos));
                        check("nos", 32'(nos), 32'(e.nos));
                        check("depth", 32'(depth), 32'(e.depth));
                        check("full", 32'(full), 32'(e.depth == DEPTH + 2));
                        check("empty", 32'(empty), 32'(e.depth == 0));
                        check("overflow", 32'(overflow), 32'(e.ovf));
                        check("underflow", 32'(underflow), 32'(e.unf));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
        clr_err   = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tos", 32'(tos), 32'd0);
        check("rst_nos", 32'(nos), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_flags", 32'({overflow, underflow}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_write_en), 32'd0);
        rst_n = 1'b1;

        // Fill to capacity
        for (int i = 0; i < 6; i++) issue(2'd1, WIDTH'(16'h11 + i), 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) check("ram_fill", 32'(ram[i]), 32'(16'h11 + i));

        // Push while full, then pop with refill
        issue(2'd1, 16'h0077, 1'b0, 1'b0);
        issue(2'd2, '0, 1'b0, 1'b0);
        // Drain to empty and pop once more
        for (int i = 0; i < 6; i++) issue(2'd2, '0, 1'b0, 1'b0);
        issue(2'd0, '0, 1'b1, 1'b0);
        // Replace at depth 3
        for (int i = 0; i < 3; i++) issue(2'd1, WIDTH'(16'h21 + i), 1'b0, 1'b0);
        issue(2'd3, 16'h00AB, 1'b0, 1'b0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            issue(2'($urandom_range(0, 3)), WIDTH'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
        end
        idle();

        // Reset asserted while the controller is refilling NOS
        while (stk.size() < 3) issue(2'd1, WIDTH'($urandom), 1'b0, 1'b0);
        issue(2'd2, '0, 1'b0, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rrst_ready", 32'(cmd_ready), 32'd1);
        check("rrst_depth", 32'(depth), 32'd0);
        check("rrst_mem_we", 32'(mem_write_en), 32'd0);
        check("rrst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        issue(2'd1, 16'h0055, 1'b0, 1'b0);
        issue(2'd1, 16'h0066, 1'b0, 1'b0);
        issue(2'd1, 16'h0077, 1'b0, 1'b0);
        issue(2'd2, '0, 1'b0, 1'b0);
        idle();

        check("wr_pending", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
